// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide unit.
// One shift-add (multiply) or restoring-division step per cycle over DBITS
// cycles, followed by a single DONE cycle that presents a registered result
// and destination index as a register-file write request.
module muldiv_unit #(
    parameter int DBITS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [3:0]       rd_in,
    input  logic [DBITS-1:0] a,
    input  logic [DBITS-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [3:0]       rd_out,
    output logic [DBITS-1:0] result
);

    localparam int CW = $clog2(DBITS);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_count;
    logic [1:0]         r_op;
    logic [3:0]         r_rd;
    logic               r_divzero;
    logic [DBITS-1:0]   r_opa;
    logic [DBITS-1:0]   r_opb;
    logic [2*DBITS-1:0] r_prod;
    logic               r_done;
    logic [3:0]         r_rd_out;
    logic [DBITS-1:0]   r_result;

    logic [DBITS:0]     w_sum;
    logic [2*DBITS-1:0] w_mul_next;
    logic [DBITS:0]     w_shrem;
    logic [DBITS+1:0]   w_diff;
    logic [2*DBITS-1:0] w_div_next;
    logic [2*DBITS-1:0] w_prod_next;
    logic [DBITS-1:0]   w_result;
    logic               w_busy;

    // State register: holds the IDLE/RUN/DONE sequencing state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, iterate in RUN, DONE lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_count == '0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic: busy covers every cycle from RUN entry through DONE.
    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    // One datapath step plus the final result selection for the latched op.
    always_comb begin
        // Multiply: lower half holds the remaining multiplier bits, upper half
        // accumulates; the carry out of the add shifts into the top bit.
        w_sum = {1'b0, r_prod[2*DBITS-1:DBITS]} + {1'b0, r_opa};
        if (r_prod[0]) begin
            w_mul_next = {w_sum, r_prod[DBITS-1:1]};
        end else begin
            w_mul_next = {1'b0, r_prod[2*DBITS-1:1]};
        end

        // Divide: the shifted remainder needs one extra bit because the
        // pre-shift remainder can be as large as divisor-1.
        w_shrem = r_prod[2*DBITS-1:DBITS-1];
        w_diff  = {1'b0, w_shrem} - {2'b00, r_opb};
        if (!w_diff[DBITS+1]) begin
            w_div_next = {w_diff[DBITS-1:0], r_prod[DBITS-2:0], 1'b1};
        end else begin
            w_div_next = {w_shrem[DBITS-1:0], r_prod[DBITS-2:0], 1'b0};
        end

        if (r_op[1]) begin
            w_prod_next = w_div_next;
        end else begin
            w_prod_next = w_mul_next;
        end

        case (r_op)
            OP_MUL:   w_result = w_prod_next[DBITS-1:0];
            OP_MULHU: w_result = w_prod_next[2*DBITS-1:DBITS];
            OP_DIVU: begin
                if (r_divzero) begin
                    w_result = '1;
                end else begin
                    w_result = w_prod_next[DBITS-1:0];
                end
            end
            OP_REMU: begin
                if (r_divzero) begin
                    w_result = r_opa;
                end else begin
                    w_result = w_prod_next[2*DBITS-1:DBITS];
                end
            end
            default:  w_result = '0;
        endcase
    end

    // Datapath registers: latch operands on accept, iterate, publish on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_op      <= 2'b00;
            r_rd      <= 4'd0;
            r_divzero <= 1'b0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_prod    <= '0;
            r_done    <= 1'b0;
            r_rd_out  <= 4'd0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op      <= op;
                        r_rd      <= rd_in;
                        r_opa     <= a;
                        r_opb     <= b;
                        r_divzero <= (b == '0);
                        r_count   <= CW'(DBITS - 1);
                        // Divide seeds the quotient side with the dividend,
                        // multiply seeds it with the multiplier.
                        if (op[1]) begin
                            r_prod <= {{DBITS{1'b0}}, a};
                        end else begin
                            r_prod <= {{DBITS{1'b0}}, b};
                        end
                    end
                end
                S_RUN: begin
                    r_prod  <= w_prod_next;
                    r_count <= r_count - 1'b1;
                    if (r_count == '0) begin
                        r_result <= w_result;
                        r_rd_out <= r_rd;
                        r_done   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = w_busy;
    assign done   = r_done;
    assign rd_out = r_rd_out;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (DBITS = 32).
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  rd_in;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [3:0]  rd_out;
    logic [31:0] result;

    int n_compared;
    int n_mismatched;

    muldiv_unit #(.DBITS(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rd_in  (rd_in),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .rd_out (rd_out),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it to completion. poke_cyc (>0) pulses an
    // extra start during RUN; poke_done pulses one in the DONE cycle.
    task automatic run_op(input string tag, input logic [1:0] t_op,
                          input logic [31:0] t_a, input logic [31:0] t_b,
                          input logic [3:0] t_rd, input logic [31:0] exp_res,
                          input int poke_cyc, input bit poke_done);
        int cyc;
        int busy_bad;
        start = 1'b1; op = t_op; a = t_a; b = t_b; rd_in = t_rd;
        tick();
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_0000; rd_in = 4'hF; op = 2'b11;
        cyc = 1;
        busy_bad = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_bad++;
            if (cyc == poke_cyc) begin
                start = 1'b1; a = 32'd9; b = 32'd9; rd_in = 4'd7; op = 2'b00;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check_val({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
        check_val({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        check_val({tag, "_result"}, 64'(result), 64'(exp_res));
        check_val({tag, "_rd_out"}, 64'(rd_out), 64'(t_rd));
        check_val({tag, "_busy_done"}, 64'(busy), 64'd1);
        if (poke_done) begin
            start = 1'b1; a = 32'd9; b = 32'd9; rd_in = 4'd7; op = 2'b00;
        end else begin
            start = 1'b0;
        end
        tick();
        start = 1'b0;
        check_val({tag, "_busy_after"}, 64'(busy), 64'd0);
        check_val({tag, "_done_after"}, 64'(done), 64'd0);
        check_val({tag, "_result_held"}, 64'(result), 64'(exp_res));
        tick();
        check_val({tag, "_still_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n_done;
        n_compared   = 0;
        n_mismatched = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        rd_in = 4'd0;
        a     = 32'd0;
        b     = 32'd0;
        tick();
        tick();
        check_val("rst_busy",   64'(busy),   64'd0);
        check_val("rst_done",   64'(done),   64'd0);
        check_val("rst_result", 64'(result), 64'd0);
        check_val("rst_rd_out", 64'(rd_out), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op("mul_7x6",   2'b00, 32'd7,         32'd6,         4'd3,  32'd42,        0, 1'b0);
        run_op("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4,  32'hFFFF_FFFE, 0, 1'b0);
        run_op("mul_max",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5,  32'h0000_0001, 0, 1'b0);
        run_op("divu_100_7",2'b10, 32'd100,       32'd7,         4'd6,  32'd14,        0, 1'b0);
        run_op("remu_100_7",2'b11, 32'd100,       32'd7,         4'd8,  32'd2,         0, 1'b0);
        run_op("divu_5_9",  2'b10, 32'd5,         32'd9,         4'd9,  32'd0,         0, 1'b0);
        run_op("remu_5_9",  2'b11, 32'd5,         32'd9,         4'd10, 32'd5,         0, 1'b0);
        run_op("divu_zero", 2'b10, 32'h0000_1234, 32'd0,         4'd11, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("remu_zero", 2'b11, 32'h0000_1234, 32'd0,         4'd12, 32'h0000_1234, 0, 1'b0);
        run_op("rd_zero",   2'b00, 32'd3,         32'd4,         4'd0,  32'd12,        0, 1'b0);
        run_op("ign_start", 2'b00, 32'd3,         32'd5,         4'd1,  32'd15,        10, 1'b1);

        // Asynchronous reset in the middle of RUN aborts with no done pulse.
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9; rd_in = 4'd13;
        tick();
        start = 1'b0;
        repeat (14) tick();
        check_val("pre_abort_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_busy",   64'(busy),   64'd0);
        check_val("abort_done",   64'(done),   64'd0);
        check_val("abort_result", 64'(result), 64'd0);
        check_val("abort_rd_out", 64'(rd_out), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        n_done = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check_val("abort_no_done", 64'(n_done), 64'd0);
        check_val("abort_idle",    64'(busy),   64'd0);

        run_op("mul_2x2", 2'b00, 32'd2, 32'd2, 4'd2, 32'd4, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
